// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit for the EX stage: shift-add multiply,
// restoring divide, one bit per cycle, with short-circuit corner cases and flush.
module muldiv_unit #(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic            flush,
   output logic            stall,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int unsigned     CW      = $clog2(XLEN + 1);
   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_e;

   state_e            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [2:0]        op_q, op_d;
   logic              sign_q, sign_d;
   logic [XLEN-1:0]   mc_q, mc_d;
   logic [2*XLEN-1:0] acc_q, acc_d;
   logic [XLEN:0]     rem_q, rem_d;
   logic [XLEN-1:0]   result_q, result_d;

   logic            a_sgn, b_sgn, neg_a, neg_b, res_sign;
   logic [XLEN-1:0] abs_a, abs_b;
   logic            div_zero, div_ovf;

   always_comb begin
      a_sgn = 1'b0;
      b_sgn = 1'b0;
      case (op)
         3'd0, 3'd1, 3'd4, 3'd6: begin
            a_sgn = 1'b1;
            b_sgn = 1'b1;
         end
         3'd2:    a_sgn = 1'b1;
         default: ;
      endcase
   end

   assign neg_a    = a_sgn & a[XLEN-1];
   assign neg_b    = b_sgn & b[XLEN-1];
   assign abs_a    = neg_a ? -a : a;
   assign abs_b    = neg_b ? -b : b;
   // REM takes the dividend's sign; every other signed op takes the XOR
   assign res_sign = (op == 3'd6) ? neg_a : (neg_a ^ neg_b);
   assign div_zero = op[2] & (b == '0);
   assign div_ovf  = op[2] & ~op[0] & (a == MIN_NEG) & (b == '1);

   logic [XLEN:0]     mul_sum;
   logic [XLEN+1:0]   div_diff;
   logic [2*XLEN-1:0] prod_s;
   logic [XLEN-1:0]   quo_s, rem_s;

   assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mc_q} : '0);
   // bit XLEN+1 of the difference is the borrow that decides restore vs. keep
   assign div_diff = {rem_q, acc_q[XLEN-1]} - {2'b00, mc_q};
   assign prod_s   = sign_q ? -acc_q : acc_q;
   assign quo_s    = sign_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
   assign rem_s    = sign_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      sign_d   = sign_q;
      mc_d     = mc_q;
      acc_d    = acc_q;
      rem_d    = rem_q;
      result_d = result_q;

      case (state_q)
         S_IDLE: begin
            if (start && !flush) begin
               op_d = op;
               if (div_zero) begin
                  result_d = op[1] ? a : '1;
                  state_d  = S_DONE;
               end else if (div_ovf) begin
                  result_d = op[1] ? '0 : a;
                  state_d  = S_DONE;
               end else begin
                  sign_d  = res_sign;
                  cnt_d   = CW'(XLEN);
                  rem_d   = '0;
                  if (op[2]) begin
                     mc_d  = abs_b;
                     acc_d = {{XLEN{1'b0}}, abs_a};
                  end else begin
                     mc_d  = abs_a;
                     acc_d = {{XLEN{1'b0}}, abs_b};
                  end
                  state_d = S_CALC;
               end
            end
         end
         S_CALC: begin
            if (op_q[2]) begin
               rem_d = div_diff[XLEN+1] ? {rem_q[XLEN-1:0], acc_q[XLEN-1]} : div_diff[XLEN:0];
               acc_d = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-2:0], ~div_diff[XLEN+1]};
            end else begin
               acc_d = {mul_sum, acc_q[XLEN-1:1]};
            end
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) state_d = S_FIX;
         end
         S_FIX: begin
            case (op_q)
               3'd0:                result_d = prod_s[XLEN-1:0];
               3'd1, 3'd2, 3'd3:    result_d = prod_s[2*XLEN-1:XLEN];
               3'd4, 3'd5:          result_d = quo_s;
               default:             result_d = rem_s;
            endcase
            state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      if (flush) begin
         state_d  = S_IDLE;
         result_d = result_q;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         op_q     <= '0;
         sign_q   <= 1'b0;
         mc_q     <= '0;
         acc_q    <= '0;
         rem_q    <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         sign_q   <= sign_d;
         mc_q     <= mc_d;
         acc_q    <= acc_d;
         rem_q    <= rem_d;
         result_q <= result_d;
      end
   end

   assign stall  = start & ~done;
   assign busy   = (state_q == S_CALC) || (state_q == S_FIX);
   assign done   = (state_q == S_DONE);
   assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: XLEN=32 and XLEN=8 instances checked against an
// arithmetic reference model, plus latency, busy/stall, flush and reset behaviour.
module tb_muldiv_unit;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        s32, f32, st32, bz32, dn32;
   logic [2:0]  op32;
   logic [31:0] a32, b32, r32;
   logic        s8, f8, st8, bz8, dn8;
   logic [2:0]  op8;
   logic [7:0]  a8, b8, r8;

   muldiv_unit #(.XLEN(32)) u32 (
      .clk(clk), .rst(rst), .start(s32), .op(op32), .a(a32), .b(b32), .flush(f32),
      .stall(st32), .busy(bz32), .done(dn32), .result(r32)
   );

   muldiv_unit #(.XLEN(8)) u8 (
      .clk(clk), .rst(rst), .start(s8), .op(op8), .a(a8), .b(b8), .flush(f8),
      .stall(st8), .busy(bz8), .done(dn8), .result(r8)
   );

   int checks = 0;
   int passes = 0;
   logic [31:0] q32[$];
   logic [7:0]  q8[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Reference: RISC-V M semantics computed with 64-bit integer arithmetic
   function automatic logic [31:0] model(input int w, input logic [2:0] op,
                                         input logic [31:0] a, input logic [31:0] b);
      longint unsigned mask, ua, ub, tmp, ru;
      longint          sa, sb, r, minv;
      mask = (64'd1 << w) - 64'd1;
      ua   = 64'(a) & mask;
      ub   = 64'(b) & mask;
      tmp  = ua << (64 - w);
      sa   = $signed(tmp) >>> (64 - w);
      tmp  = ub << (64 - w);
      sb   = $signed(tmp) >>> (64 - w);
      minv = -(longint'(1) << (w - 1));
      case (op)
         3'd0:    r = sa * sb;
         3'd1:    r = (sa * sb) >>> w;
         3'd2:    r = (sa * $signed(ub)) >>> w;
         3'd3:    r = $signed((ua * ub) >> w);
         3'd4:    r = (ub == 0) ? longint'(-1) : ((sa == minv && sb == -1) ? sa : sa / sb);
         3'd5:    r = (ub == 0) ? longint'(-1) : $signed(ua / ub);
         3'd6:    r = (ub == 0) ? sa : ((sa == minv && sb == -1) ? longint'(0) : sa % sb);
         default: r = (ub == 0) ? $signed(ua) : $signed(ua % ub);
      endcase
      ru = $unsigned(r) & mask;
      return ru[31:0];
   endfunction

   function automatic int latency(input int w, input logic [2:0] op,
                                  input logic [31:0] a, input logic [31:0] b);
      logic [31:0] m, mn;
      m  = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_00FF;
      mn = 32'd1 << (w - 1);
      if (op[2] && (((b & m) == 0) || (!op[0] && (a & m) == mn && (b & m) == m))) return 1;
      return w + 2;
   endfunction

   function automatic logic [31:0] pick(input int w);
      logic [31:0] m;
      m = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_00FF;
      case ($urandom_range(0, 5))
         0:       return 32'd0;
         1:       return 32'd1 << (w - 1);
         2:       return m;
         3:       return 32'($urandom_range(0, 20));
         default: return $urandom & m;
      endcase
   endfunction

   initial forever begin
      @(negedge clk);
      if (dn32) begin
         if (q32.size() == 0) chk("unexpected done32", 1, 0);
         else chk("result32", r32, q32.pop_front());
      end
      if (dn8) begin
         if (q8.size() == 0) chk("unexpected done8", 1, 0);
         else chk("result8", r8, q8.pop_front());
      end
   end

   task automatic run(input bit w8, input logic [2:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] exp, input int lat);
      int    k, busyc, stallbad;
      bit    got;
      string tag;
      tag = $sformatf("w%0d op%0d a=%0h b=%0h", w8 ? 8 : 32, op, a, b);
      @(posedge clk); #1;
      if (w8) begin
         q8.push_back(exp[7:0]);
         op8 = op; a8 = a[7:0]; b8 = b[7:0]; s8 = 1'b1;
      end else begin
         q32.push_back(exp);
         op32 = op; a32 = a; b32 = b; s32 = 1'b1;
      end
      #1;
      stallbad = (w8 ? st8 : st32) ? 0 : 1;
      busyc = 0; k = 0; got = 1'b0;
      while (!got && k < 100) begin
         @(posedge clk); #1;
         k++;
         if (w8 ? dn8 : dn32) got = 1'b1;
         else begin
            if (w8 ? bz8 : bz32) busyc++;
            if (!(w8 ? st8 : st32)) stallbad++;
         end
      end
      chk({tag, " latency"}, got ? k : 999, lat);
      chk({tag, " busy cycles"}, busyc, lat - 1);
      chk({tag, " stall gaps"}, stallbad, 0);
      chk({tag, " stall at done"}, w8 ? st8 : st32, 0);
   endtask

   task automatic idle(input bit w8);
      @(posedge clk); #1;
      if (w8) s8 = 1'b0; else s32 = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] prev, x, y, e;
      logic [2:0]  o;
      int          dcount;
      rst = 1'b0;
      s32 = 0; f32 = 0; op32 = 0; a32 = 0; b32 = 0;
      s8 = 0;  f8 = 0;  op8 = 0;  a8 = 0;  b8 = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset busy32", bz32, 0);
      chk("reset done32", dn32, 0);
      chk("reset result32", r32, 0);
      chk("reset stall32", st32, 0);
      chk("reset busy8", bz8, 0);
      chk("reset done8", dn8, 0);
      chk("reset result8", r8, 0);
      @(negedge clk) rst = 1'b1;

      run(0, 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);

      // flush in cycle t+10 of a DIV; result must keep the previous value
      @(posedge clk); #1;
      prev = r32;
      op32 = 3'd4; a32 = 32'd1000; b32 = 32'd3; s32 = 1'b1;
      dcount = 0;
      for (int k = 1; k <= 10; k++) begin
         @(posedge clk); #1;
         if (dn32) dcount++;
         if (k == 10) f32 = 1'b1;
      end
      @(posedge clk); #1;
      chk("flush busy", bz32, 0);
      chk("flush done", dn32, 0);
      chk("flush result held", r32, prev);
      chk("flush no early done", dcount, 0);
      f32 = 1'b0; s32 = 1'b0;
      run(0, 3'd0, 32'h0000_1234, 32'h0000_0010, 32'h0001_2340, 34);

      run(0, 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34);
      run(0, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
      run(0, 3'd2, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 34);
      run(0, 3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34);
      run(0, 3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34);
      run(0, 3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF, 1);
      run(0, 3'd6, 32'd5,         32'd0,         32'd5,         1);
      run(0, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
      run(0, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);
      run(0, 3'd7, 32'd100,       32'd7,         32'd2,         34);
      run(0, 3'd5, 32'd100,       32'd7,         32'd14,        34);

      // asynchronous reset in cycle t+5 of a DIVU
      @(posedge clk); #1;
      op32 = 3'd5; a32 = 32'd12345; b32 = 32'd7; s32 = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk("mid-op reset busy", bz32, 0);
      chk("mid-op reset done", dn32, 0);
      chk("mid-op reset result", r32, 0);
      s32 = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset held busy", bz32, 0);
      rst = 1'b1;
      repeat (3) @(posedge clk);

      for (int i = 0; i < 40; i++) begin
         o = 3'($urandom_range(0, 7));
         x = pick(32);
         y = pick(32);
         e = model(32, o, x, y);
         run(0, o, x, y, e, latency(32, o, x, y));
         if ($urandom_range(0, 3) == 0) idle(0);
      end
      idle(0);

      run(1, 3'd4, 32'h80, 32'hFF, 32'h80, 1);
      run(1, 3'd0, 32'h0F, 32'h11, 32'hFF, 10);
      for (int i = 0; i < 40; i++) begin
         o = 3'($urandom_range(0, 7));
         x = pick(8);
         y = pick(8);
         e = model(8, o, x, y);
         run(1, o, x, y, e, latency(8, o, x, y));
         if ($urandom_range(0, 3) == 0) idle(1);
      end
      idle(1);

      repeat (5) @(posedge clk);
      #1;
      chk("scoreboard32 drained", q32.size(), 0);
      chk("scoreboard8 drained", q8.size(), 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
